id_stage: RTL and testbench

Instruction-decode pipeline stage of the RV32I datapath, sitting between fetch and execute and driving the read ports of `register_file`. It drives `register_file` read addresses from the incoming instruction and decodes control signals and the immediate. It captures operands, controls and metadata into an ID/EX pipeline register using a valid/ready handshake. It also detects load-use hazards and inserts one bubble per hazard. An optional write-back bypass covers same-edge writes.

---
 rtl/id_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I instruction-decode stage with ID/EX pipeline register.
// Decodes control and immediate, drives register-file read addresses, stalls
// one cycle on load-use hazards. Optional write-back bypass: ID_WB_BYPASS_EN.
module id_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_we,
    input  logic [4:0]      wb_a3,
    input  logic [XLEN-1:0] wb_wd,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_alu_src,
    output logic [1:0]      ex_result_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [3:0] AluAdd   = 4'd0;
    localparam logic [3:0] AluSub   = 4'd1;
    localparam logic [3:0] AluSll   = 4'd2;
    localparam logic [3:0] AluSlt   = 4'd3;
    localparam logic [3:0] AluSltu  = 4'd4;
    localparam logic [3:0] AluXor   = 4'd5;
    localparam logic [3:0] AluSrl   = 4'd6;
    localparam logic [3:0] AluSra   = 4'd7;
    localparam logic [3:0] AluOr    = 4'd8;
    localparam logic [3:0] AluAnd   = 4'd9;
    localparam logic [3:0] AluPassb = 4'd10;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_f, rs2_f, rd_f;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign funct7 = if_instr[31:25];
    assign rs1_f  = if_instr[19:15];
    assign rs2_f  = if_instr[24:20];
    assign rd_f   = if_instr[11:7];
    assign rf_a1  = rs1_f;
    assign rf_a2  = rs2_f;

    logic [XLEN-1:0] dec_imm;
    logic [3:0]      dec_alu_ctrl;
    logic [1:0]      dec_result_src;
    logic            dec_alu_src, dec_reg_write, dec_mem_read, dec_mem_write;
    logic            dec_branch, dec_jump, dec_illegal, dec_pc_a;
    logic            use_rs1, use_rs2;

    // Decode the incoming instruction into controls and an immediate.
    always_comb begin
        dec_imm        = {{20{if_instr[31]}}, if_instr[31:20]};
        dec_alu_ctrl   = AluAdd;
        dec_result_src = 2'd0;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_illegal    = 1'b0;
        dec_pc_a       = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (opcode)
            OpLui: begin
                dec_imm       = {if_instr[31:12], 12'b0};
                dec_alu_ctrl  = AluPassb;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpAuipc: begin
                dec_imm       = {if_instr[31:12], 12'b0};
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_pc_a      = 1'b1;
            end
            OpJal: begin
                dec_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                           if_instr[30:21], 1'b0};
                dec_alu_src    = 1'b1;
                dec_result_src = 2'd2;
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
            end
            OpJalr: begin
                dec_alu_src    = 1'b1;
                dec_result_src = 2'd2;
                dec_reg_write  = 1'b1;
                dec_jump       = 1'b1;
                use_rs1        = 1'b1;
                dec_illegal    = (funct3 != 3'b000);
            end
            OpBranch: begin
                dec_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                           if_instr[11:8], 1'b0};
                dec_branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec_alu_ctrl = AluSub;
                    3'b100, 3'b101: dec_alu_ctrl = AluSlt;
                    3'b110, 3'b111: dec_alu_ctrl = AluSltu;
                    default:        dec_illegal  = 1'b1;
                endcase
            end
            OpLoad: begin
                dec_alu_src    = 1'b1;
                dec_result_src = 2'd1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                use_rs1        = 1'b1;
                dec_illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                                 (funct3 == 3'b111);
            end
            OpStore: begin
                dec_imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_illegal   = (funct3 > 3'b010);
            end
            OpImm: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                use_rs1       = 1'b1;
                case (funct3)
                    3'b000: dec_alu_ctrl = AluAdd;
                    3'b010: dec_alu_ctrl = AluSlt;
                    3'b011: dec_alu_ctrl = AluSltu;
                    3'b100: dec_alu_ctrl = AluXor;
                    3'b110: dec_alu_ctrl = AluOr;
                    3'b111: dec_alu_ctrl = AluAnd;
                    3'b001: begin
                        dec_alu_ctrl = AluSll;
                        dec_illegal  = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec_alu_ctrl = funct7[5] ? AluSra : AluSrl;
                        dec_illegal  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                endcase
            end
            OpReg: begin
                dec_reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                case (funct3)
                    3'b000:  dec_alu_ctrl = funct7[5] ? AluSub : AluAdd;
                    3'b001:  dec_alu_ctrl = AluSll;
                    3'b010:  dec_alu_ctrl = AluSlt;
                    3'b011:  dec_alu_ctrl = AluSltu;
                    3'b100:  dec_alu_ctrl = AluXor;
                    3'b101:  dec_alu_ctrl = funct7[5] ? AluSra : AluSrl;
                    3'b110:  dec_alu_ctrl = AluOr;
                    default: dec_alu_ctrl = AluAnd;
                endcase
                // Only SUB and SRA may carry funct7 = 0100000.
                if (funct7 == 7'b0100000) begin
                    dec_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else begin
                    dec_illegal = (funct7 != 7'b0000000);
                end
            end
            OpFence, OpSystem: ;
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_reg_write = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_branch    = 1'b0;
            dec_jump      = 1'b0;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
        end
        if (rd_f == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d, ex_rs1_val_q, ex_rs1_val_d;
    logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d, ex_imm_q, ex_imm_d;
    logic [4:0]      ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
    logic [3:0]      ex_alu_ctrl_q, ex_alu_ctrl_d;
    logic [1:0]      ex_result_src_q, ex_result_src_d;
    logic            ex_alu_src_q, ex_alu_src_d, ex_reg_write_q, ex_reg_write_d;
    logic            ex_mem_read_q, ex_mem_read_d, ex_mem_write_q, ex_mem_write_d;
    logic            ex_branch_q, ex_branch_d, ex_jump_q, ex_jump_d;
    logic            ex_illegal_q, ex_illegal_d;

    logic            hazard, accept;
    logic [XLEN-1:0] op1_val, op2_val;

    // Load-use hazard against the load sitting in ID/EX; clears once it leaves.
    always_comb begin
        hazard = ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0) &&
                 ((use_rs1 && (ex_rd_q == rs1_f)) || (use_rs2 && (ex_rd_q == rs2_f)));
        if_ready = (~ex_valid_q | ex_ready) & ~hazard;
        accept   = if_valid & if_ready;
    end

`ifdef ID_WB_BYPASS_EN
    // Same-edge write-back overrides the stale register-file read.
    always_comb begin
        op1_val = (wb_we && (wb_a3 != 5'd0) && (wb_a3 == rs1_f)) ? wb_wd : rf_rd1;
        op2_val = (wb_we && (wb_a3 != 5'd0) && (wb_a3 == rs2_f)) ? wb_wd : rf_rd2;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_a3, wb_wd};
    // Register file is assumed to write before read.
    always_comb begin
        op1_val = rf_rd1;
        op2_val = rf_rd2;
    end
`endif

    // ID/EX next state: flush kills, accept loads, consume without accept drains.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_rs1_val_d    = ex_rs1_val_q;
        ex_rs2_val_d    = ex_rs2_val_q;
        ex_imm_d        = ex_imm_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_alu_ctrl_d   = ex_alu_ctrl_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_result_src_d = ex_result_src_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_branch_d     = ex_branch_q;
        ex_jump_d       = ex_jump_q;
        ex_illegal_d    = ex_illegal_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d      = 1'b1;
            ex_pc_d         = if_pc;
            // AUIPC presents the PC as operand A so execute needs no extra mux select.
            ex_rs1_val_d    = dec_pc_a ? if_pc : op1_val;
            ex_rs2_val_d    = op2_val;
            ex_imm_d        = dec_imm;
            ex_rs1_d        = use_rs1 ? rs1_f : 5'd0;
            ex_rs2_d        = use_rs2 ? rs2_f : 5'd0;
            ex_rd_d         = dec_reg_write ? rd_f : 5'd0;
            ex_alu_ctrl_d   = dec_alu_ctrl;
            ex_alu_src_d    = dec_alu_src;
            ex_result_src_d = dec_result_src;
            ex_reg_write_d  = dec_reg_write;
            ex_mem_read_d   = dec_mem_read;
            ex_mem_write_d  = dec_mem_write;
            ex_branch_d     = dec_branch;
            ex_jump_d       = dec_jump;
            ex_illegal_d    = dec_illegal;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // ID/EX register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs1_val_q    <= '0;
            ex_rs2_val_q    <= '0;
            ex_imm_q        <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_alu_ctrl_q   <= '0;
            ex_alu_src_q    <= 1'b0;
            ex_result_src_q <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_jump_q       <= 1'b0;
            ex_illegal_q    <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_val_q    <= ex_rs1_val_d;
            ex_rs2_val_q    <= ex_rs2_val_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_alu_ctrl_q   <= ex_alu_ctrl_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_result_src_q <= ex_result_src_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_branch_q     <= ex_branch_d;
            ex_jump_q       <= ex_jump_d;
            ex_illegal_q    <= ex_illegal_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1_val    = ex_rs1_val_q;
    assign ex_rs2_val    = ex_rs2_val_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_alu_ctrl   = ex_alu_ctrl_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_result_src = ex_result_src_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_branch     = ex_branch_q;
    assign ex_jump       = ex_jump_q;
    assign ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expectations.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, if_ready;
    logic [31:0] if_instr, if_pc, rf_rd1, rf_rd2, wb_wd;
    logic [4:0]  rf_a1, rf_a2, wb_a3;
    logic        wb_we, ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src;
    logic [1:0]  ex_result_src;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src), .ex_result_src(ex_result_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        rf_rd1 = 32'h0; rf_rd2 = 32'h0; wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'h0;
        ex_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_pc", ex_pc, 32'd0);
        check("reset_imm", ex_imm, 32'd0);
        check("reset_alu", {28'd0, ex_alu_ctrl}, 32'd0);
        check("reset_regwrite", {31'd0, ex_reg_write}, 32'd0);

        // addi x5,x0,5
        present(32'h00500293, 32'h100);
        check("addi_a1", {27'd0, rf_a1}, 32'd0);
        check("addi_a2", {27'd0, rf_a2}, 32'd5);
        check("addi_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("addi_valid", {31'd0, ex_valid}, 32'd1);
        check("addi_rd", {27'd0, ex_rd}, 32'd5);
        check("addi_rs1", {27'd0, ex_rs1}, 32'd0);
        check("addi_imm", ex_imm, 32'd5);
        check("addi_alu", {28'd0, ex_alu_ctrl}, 32'd0);
        check("addi_src", {31'd0, ex_alu_src}, 32'd1);
        check("addi_regwrite", {31'd0, ex_reg_write}, 32'd1);
        check("addi_pc", ex_pc, 32'h100);

        // lw x6,0(x5)
        present(32'h0002A303, 32'h104);
        tick();
        check("lw_memread", {31'd0, ex_mem_read}, 32'd1);
        check("lw_rd", {27'd0, ex_rd}, 32'd6);
        check("lw_ressrc", {30'd0, ex_result_src}, 32'd1);

        // add x7,x6,x5 depends on the load: one bubble
        present(32'h005303B3, 32'h108);
        check("hazard_ready", {31'd0, if_ready}, 32'd0);
        tick();
        check("bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("after_bubble_ready", {31'd0, if_ready}, 32'd1);
        tick();
        check("add_valid", {31'd0, ex_valid}, 32'd1);
        check("add_rs1", {27'd0, ex_rs1}, 32'd6);
        check("add_rs2", {27'd0, ex_rs2}, 32'd5);
        check("add_rd", {27'd0, ex_rd}, 32'd7);
        check("add_pc", ex_pc, 32'h108);

        // beq x0,x0,-4
        present(32'hFE000EE3, 32'h10C);
        tick();
        check("beq_imm", ex_imm, 32'hFFFFFFFC);
        check("beq_branch", {31'd0, ex_branch}, 32'd1);
        check("beq_alu", {28'd0, ex_alu_ctrl}, 32'd1);
        check("beq_regwrite", {31'd0, ex_reg_write}, 32'd0);

        // add x8,x5,x6 with same-edge write-back to x5
        wb_we = 1'b1; wb_a3 = 5'd5; wb_wd = 32'hAAAA5555;
        rf_rd1 = 32'h0; rf_rd2 = 32'h12345678;
        present(32'h00628433, 32'h110);
        tick();
        wb_we = 1'b0;
`ifdef ID_WB_BYPASS_EN
        check("bypass_rs1", ex_rs1_val, 32'hAAAA5555);
`else
        check("bypass_rs1", ex_rs1_val, 32'h0);
`endif
        check("bypass_rs2", ex_rs2_val, 32'h12345678);

        // Illegal word
        present(32'hFFFFFFFF, 32'h114);
        tick();
        check("ill_flag", {31'd0, ex_illegal}, 32'd1);
        check("ill_flags", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump},
              32'd0);

        // addi x0,x0,1 never writes
        present(32'h00100013, 32'h118);
        tick();
        check("rd0_regwrite", {31'd0, ex_reg_write}, 32'd0);
        check("rd0_illegal", {31'd0, ex_illegal}, 32'd0);

        // sw x6,8(x5), then backpressure
        present(32'h0062A423, 32'h200);
        tick();
        check("sw_memwrite", {31'd0, ex_mem_write}, 32'd1);
        check("sw_imm", ex_imm, 32'd8);
        ex_ready = 1'b0;
        present(32'h00500293, 32'h204);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {31'd0, if_ready}, 32'd0);
            tick();
            check("stall_valid", {31'd0, ex_valid}, 32'd1);
            check("stall_pc", ex_pc, 32'h200);
            check("stall_imm", ex_imm, 32'd8);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        #1;
        check("flush_ready", {31'd0, if_ready}, 32'd1);

        // lui x10,0x12345
        ex_ready = 1'b1;
        present(32'h12345537, 32'h300);
        tick();
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_alu", {28'd0, ex_alu_ctrl}, 32'd10);
        check("lui_rd", {27'd0, ex_rd}, 32'd10);
        if_valid = 1'b0;
        tick();
        check("drain_valid", {31'd0, ex_valid}, 32'd0);

        // Reset during a load-use stall
        present(32'h0002A303, 32'h400);
        tick();
        ex_ready = 1'b0;
        present(32'h005303B3, 32'h404);
        check("stall2_ready", {31'd0, if_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_memread", {31'd0, ex_mem_read}, 32'd0);
        check("rst_ready", {31'd0, if_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
